// File: rtl/clk_meter_pkg.sv
// Shared types and constants for the clock frequency / duty meter.
// FSM state encoding and result scaling live here.
package clk_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RISE,
        MEASURE
    } meter_state_t;

    localparam int DUTY_W    = 7;
    localparam int PCT_SCALE = 100;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// done is asserted during the final iteration, together with quot.
module seq_divider #(
    parameter int N_W = 23,
    parameter int D_W = 16,
    parameter int Q_W = 7
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    input  logic [N_W-1:0] num,
    input  logic [D_W-1:0] den,
    output logic           busy,
    output logic           done,
    output logic [Q_W-1:0] quot
);

    localparam int C_W = $clog2(N_W + 1);

    logic [D_W-1:0] rem;
    logic [D_W-1:0] den_r;
    logic [N_W-1:0] q;
    logic [C_W-1:0] cnt;
    logic [D_W:0]   rem_sh;
    logic [D_W:0]   diff;
    logic [D_W-1:0] rem_next;
    logic [N_W-1:0] q_next;
    logic           last;

    // Remainder stays below den, so one extra bit holds the shifted value.
    always_comb begin
        rem_sh = {rem, q[N_W-1]};
        diff   = rem_sh - {1'b0, den_r};
        if (diff[D_W]) begin
            rem_next = rem_sh[D_W-1:0];
            q_next   = {q[N_W-2:0], 1'b0};
        end else begin
            rem_next = diff[D_W-1:0];
            q_next   = {q[N_W-2:0], 1'b1};
        end
    end

    assign last = busy && (cnt == C_W'(1));
    assign done = last && !abort;
    assign quot = q_next[Q_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy  <= 1'b0;
            cnt   <= '0;
            rem   <= '0;
            q     <= '0;
            den_r <= '0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start && !busy) begin
            busy  <= 1'b1;
            cnt   <= C_W'(N_W);
            rem   <= '0;
            q     <= num;
            den_r <= den;
        end else if (busy) begin
            rem <= rem_next;
            q   <= q_next;
            cnt <= cnt - C_W'(1);
            if (last) busy <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_freq_duty_meter.sv
// Measures period and high time of an async signal in clk cycles
// and reports duty in percent, with stall detection.
module clk_freq_duty_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_in,
    input  logic              enable,
    output logic [CNT_W-1:0]  period_cyc,
    output logic [CNT_W-1:0]  high_cyc,
    output logic [DUTY_W-1:0] duty_pct,
    output logic              meas_valid,
    output logic              stalled,
    output logic              busy
);

    localparam int NUM_W = CNT_W + DUTY_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    meter_state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s, s_d, rise;
    logic [CNT_W-1:0]       per_cnt, hi_cnt;
    logic [CNT_W-1:0]       per_snap, hi_snap;
    logic                   close, stall_hit, div_start;
    logic                   div_done;
    logic [DUTY_W-1:0]      div_quot;
    logic [NUM_W-1:0]       num;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= '0;
            s_d  <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
            s_d  <= s;
        end
    end

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s && !s_d;

    assign close     = enable && (state == MEASURE) && rise;
    assign stall_hit = enable && (state == MEASURE) && !rise
                       && (per_cnt == CNT_MAX);
    assign div_start = close && !busy;
    assign num       = NUM_W'(hi_cnt) * NUM_W'(PCT_SCALE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (!enable) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE:      state_next = WAIT_RISE;
                WAIT_RISE: if (rise) state_next = MEASURE;
                MEASURE:   if (stall_hit) state_next = WAIT_RISE;
                default:   state_next = IDLE;
            endcase
        end
    end

    // A rise reloads to 1: the rise cycle itself belongs to the new period.
    always_ff @(posedge clk) begin
        if (!rst_n || !enable || state == IDLE) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else if (state == MEASURE) begin
            if (per_cnt == CNT_MAX) begin
                per_cnt <= '0;
                hi_cnt  <= '0;
            end else begin
                per_cnt <= per_cnt + CNT_W'(1);
                if (s) hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            per_snap <= '0;
            hi_snap  <= '0;
        end else if (div_start) begin
            per_snap <= per_cnt;
            hi_snap  <= hi_cnt;
        end
    end

    seq_divider #(
        .N_W (NUM_W),
        .D_W (CNT_W),
        .Q_W (DUTY_W)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .abort (!enable),
        .num   (num),
        .den   (per_cnt),
        .busy  (busy),
        .done  (div_done),
        .quot  (div_quot)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cyc <= '0;
            high_cyc   <= '0;
            duty_pct   <= '0;
            meas_valid <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= div_done;
            if (div_done) begin
                period_cyc <= per_snap;
                high_cyc   <= hi_snap;
                duty_pct   <= div_quot;
                stalled    <= 1'b0;
            end else if (stall_hit) begin
                stalled <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_freq_duty_meter.sv
// Directed bench for clk_freq_duty_meter: default width instance
// plus an 8-bit instance for the stall path.
module tb_clk_freq_duty_meter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sig, en;
    logic [15:0] period_cyc, high_cyc;
    logic [6:0]  duty_pct;
    logic        meas_valid, stalled, busy;

    logic        sig8, en8;
    logic [7:0]  period8, high8;
    logic [6:0]  duty8;
    logic        valid8, stalled8, busy8;

    int n_chk  = 0;
    int n_fail = 0;
    int tcyc   = 0;

    int g_on = 0, g_per = 10, g_hi = 5, g_ph = 0;
    int g8_on = 0, g8_ph = 0;

    int nvalid = 0, nvalid8 = 0;
    int mcyc = 0, busy_rise = 0, busy_len = 0, lat = 0;
    logic busy_q = 1'b0;

    always #5 clk = ~clk;

    clk_freq_duty_meter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig),
        .enable     (en),
        .period_cyc (period_cyc),
        .high_cyc   (high_cyc),
        .duty_pct   (duty_pct),
        .meas_valid (meas_valid),
        .stalled    (stalled),
        .busy       (busy)
    );

    clk_freq_duty_meter #(.CNT_W(8)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .sig_in     (sig8),
        .enable     (en8),
        .period_cyc (period8),
        .high_cyc   (high8),
        .duty_pct   (duty8),
        .meas_valid (valid8),
        .stalled    (stalled8),
        .busy       (busy8)
    );

    task automatic check(input string tag, input longint obs,
                         input longint exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Waveform generator, updates on negedge so sampling is clean.
    initial begin
        sig = 1'b0;
        forever begin
            @(negedge clk);
            if (g_on != 0) begin
                sig  = (g_ph < g_hi);
                g_ph = (g_ph + 1 >= g_per) ? 0 : g_ph + 1;
            end else if (g8_on == 0) begin
                sig = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (g8_on != 0) begin
                sig8  = (g8_ph < 5);
                g8_ph = (g8_ph + 1 >= 10) ? 0 : g8_ph + 1;
            end
        end
    end

    // Monitor on negedge: busy run length, valid latency, duty range.
    always @(negedge clk) begin
        mcyc++;
        if (busy && !busy_q) busy_rise = mcyc;
        if (!busy && busy_q) busy_len = mcyc - busy_rise;
        busy_q = busy;
        if (meas_valid) begin
            nvalid++;
            lat = mcyc - busy_rise;
            check("duty_range", longint'(duty_pct <= 7'd100), 1);
        end
        if (valid8) nvalid8++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            tcyc++;
        end
    endtask

    task automatic wait_valid(input string tag, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick(1);
            if (meas_valid) seen = 1;
        end
        check({tag, "_seen"}, seen, 1);
    endtask

    task automatic wait_busy(input string tag, input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick(1);
            if (busy) seen = 1;
        end
        check({tag, "_busy"}, seen, 1);
    endtask

    task automatic run_wave(input string tag, input int per, input int hi,
                            input int duty);
        en   = 1'b0;
        g_on = 0;
        tick(3);
        g_per = per;
        g_hi  = hi;
        g_ph  = 0;
        g_on  = 1;
        en    = 1'b1;
        wait_valid(tag, 3 * per + 60);
        check({tag, "_per"}, period_cyc, per);
        check({tag, "_hi"}, high_cyc, hi);
        check({tag, "_duty"}, duty_pct, duty);
    endtask

    initial begin
        int c0, nv0, n;
        bit st_prev, seen;
        rst_n = 1'b0;
        en    = 1'b0;
        en8   = 1'b0;
        sig8  = 1'b0;
        tick(4);
        check("rst_per", period_cyc, 0);
        check("rst_hi", high_cyc, 0);
        check("rst_duty", duty_pct, 0);
        check("rst_valid", meas_valid, 0);
        check("rst_stalled", stalled, 0);
        check("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick(2);

        // 50% square: one result every third period, 24-cycle latency.
        run_wave("w10_5", 10, 5, 50);
        check("stalled_0", stalled, 0);
        c0 = tcyc;
        tick(1);
        check("valid_pulse", meas_valid, 0);
        wait_valid("w10_5b", 60);
        check("gap", tcyc - c0, 30);
        tick(1);
        check("latency", lat, 23);
        check("busy_len", busy_len, 23);

        run_wave("w10_3", 10, 3, 30);
        run_wave("w100_99", 100, 99, 99);
        run_wave("w3_1", 3, 1, 33);
        run_wave("w7_6", 7, 6, 85);
        run_wave("w250_1", 250, 1, 0);

        // Drop enable mid-division: abort, outputs retained.
        en   = 1'b0;
        g_on = 0;
        tick(3);
        g_per = 10;
        g_hi  = 5;
        g_ph  = 0;
        g_on  = 1;
        en    = 1'b1;
        wait_busy("abort", 60);
        tick(5);
        en = 1'b0;
        nv0 = nvalid;
        tick(1);
        check("abort_busy", busy, 0);
        tick(40);
        check("abort_novalid", nvalid - nv0, 0);
        check("abort_per", period_cyc, 250);
        check("abort_hi", high_cyc, 1);
        check("abort_duty", duty_pct, 0);
        en = 1'b1;
        wait_valid("reen", 80);
        check("reen_per", period_cyc, 10);
        check("reen_hi", high_cyc, 5);
        check("reen_duty", duty_pct, 50);

        // Reset while measuring, then while dividing.
        tick(3);
        rst_n = 1'b0;
        tick(1);
        check("rm_per", period_cyc, 0);
        check("rm_duty", duty_pct, 0);
        rst_n = 1'b1;
        wait_valid("rm_rec", 80);
        check("rm_rec_per", period_cyc, 10);
        wait_busy("rd", 60);
        tick(4);
        rst_n = 1'b0;
        tick(1);
        check("rd_per", period_cyc, 0);
        check("rd_hi", high_cyc, 0);
        check("rd_duty", duty_pct, 0);
        check("rd_valid", meas_valid, 0);
        check("rd_stalled", stalled, 0);
        check("rd_busy", busy, 0);
        tick(2);
        rst_n = 1'b1;
        nv0 = nvalid;
        tick(20);
        check("rd_novalid", nvalid - nv0, 0);
        wait_valid("rd_rec", 80);
        check("rd_rec_duty", duty_pct, 50);
        en   = 1'b0;
        g_on = 0;

        // Stall on the 8-bit instance: one pulse then held low.
        en8 = 1'b1;
        tick(3);
        @(negedge clk);
        sig8 = 1'b1;
        n = 0;
        seen = 0;
        while (!seen && n < 400) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 3) sig8 = 1'b0;
            if (stalled8) seen = 1;
        end
        check("stall_seen", seen, 1);
        check("stall_cyc", n, 258);
        tick(40);
        check("stall_hold", stalled8, 1);
        check("stall_novalid", nvalid8, 0);
        g8_ph = 0;
        g8_on = 1;
        seen = 0;
        st_prev = stalled8;
        for (int i = 0; i < 80 && !seen; i++) begin
            st_prev = stalled8;
            tick(1);
            if (valid8) seen = 1;
        end
        check("sq8_seen", seen, 1);
        check("sq8_stalled_before", st_prev, 1);
        check("sq8_stalled", stalled8, 0);
        check("sq8_per", period8, 10);
        check("sq8_hi", high8, 5);
        check("sq8_duty", duty8, 50);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
